// File: rtl/int_ctrl_vec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : int_ctrl_vec                                                  |
// | Purpose  : Vectored interrupt controller for the Nano CPU 8-bit I/O bus. |
// |            Up to 8 sources with per-channel enable, edge/level mode,     |
// |            latched pending, software set and write-1-to-clear. Fixed    |
// |            priority (lowest index wins), registered irq/irq_id to the   |
// |            CPU and an ack / in-service / EOI handshake.                  |
// | Ports    : clk, rst      clock, synchronous active-high reset            |
// |            add, data_i   bus address / write data, we write strobe      |
// |            data_o        combinational read data (0 when not decoded)   |
// |            eint          interrupt sources (synchronous to clk)         |
// |            irq, irq_id   request and requesting channel index           |
// |            irq_ack       CPU accepts current request (1-cycle pulse)    |
// |            ack           one-hot 1-cycle pulse to the accepted source   |
// |            in_svc        handler in service                             |
// | Register map (offset from BASE_ADD):                                     |
// |            +0 EN  +1 PEND(W1C)  +2 SWI(W)  +3 MODE  +4 STAT(W = EOI)    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module int_ctrl_vec #(
  parameter int         NCH      = 3,
  parameter logic [7:0] BASE_ADD = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     add,
  input  logic [7:0]     data_i,
  output logic [7:0]     data_o,
  input  logic           we,
  input  logic [NCH-1:0] eint,
  output logic           irq,
  output logic [2:0]     irq_id,
  input  logic           irq_ack,
  output logic [NCH-1:0] ack,
  output logic           in_svc
);

  localparam logic [7:0] c_off_en   = 8'd0;
  localparam logic [7:0] c_off_pend = 8'd1;
  localparam logic [7:0] c_off_swi  = 8'd2;
  localparam logic [7:0] c_off_mode = 8'd3;
  localparam logic [7:0] c_off_stat = 8'd4;
  // Channels that physically exist; bits above NCH read 0 and ignore writes.
  localparam logic [7:0] c_mask     = 8'((16'd1 << NCH) - 16'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SVC  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     r_en;
  logic [7:0]     r_pend;
  logic [7:0]     r_mode;
  logic [7:0]     r_eint_q;
  logic [2:0]     r_irq_id;
  logic [NCH-1:0] r_ack;

  logic [7:0]     w_off;
  logic [7:0]     w_wdata;
  logic [7:0]     w_eint8;
  logic           w_wr_en;
  logic           w_wr_pend;
  logic           w_wr_swi;
  logic           w_wr_mode;
  logic           w_wr_stat;
  logic [7:0]     w_set;
  logic [7:0]     w_clr;
  logic [7:0]     w_req;
  logic [2:0]     w_sel;
  logic [2:0]     w_id_nxt;
  logic           w_accept;
  logic [7:0]     w_ack_clr;
  logic [NCH-1:0] w_ack_nxt;

  // ---------------- bus decode ----------------
  // Offset arithmetic wraps in 8 bits, so a block near 8'hFF still decodes.
  assign w_off     = add - BASE_ADD;
  assign w_wdata   = data_i & c_mask;
  assign w_wr_en   = we && (w_off == c_off_en);
  assign w_wr_pend = we && (w_off == c_off_pend);
  assign w_wr_swi  = we && (w_off == c_off_swi);
  assign w_wr_mode = we && (w_off == c_off_mode);
  assign w_wr_stat = we && (w_off == c_off_stat);

  always_comb begin
    w_eint8          = 8'h00;
    w_eint8[NCH-1:0] = eint;
  end

  always_comb begin
    data_o = 8'h00;
    case (w_off)
      c_off_en:   data_o = r_en;
      c_off_pend: data_o = r_pend;
      c_off_swi:  data_o = 8'h00;
      c_off_mode: data_o = r_mode;
      c_off_stat: data_o = {irq, in_svc, 3'b000, r_irq_id};
      default:    data_o = 8'h00;
    endcase
  end

  // ---------------- pending logic ----------------
  // Edge channels see a rising edge against last cycle's sample; level
  // channels set every cycle the source is high.
  assign w_set = (r_mode & w_eint8 & ~r_eint_q)
               | (~r_mode & w_eint8)
               | (w_wr_swi ? w_wdata : 8'h00);

  assign w_ack_clr = w_accept ? (8'h01 << r_irq_id) : 8'h00;
  assign w_clr     = (w_wr_pend ? w_wdata : 8'h00) | w_ack_clr;
  assign w_req     = r_pend & r_en;

  // Lowest-index requesting channel; scanning downward lets the lowest
  // set bit be the last assignment.
  always_comb begin
    w_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_req[i]) begin
        w_sel = 3'(i);
      end
    end
  end

  // ---------------- handshake FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_irq_id;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_state_nxt = S_REQ;
          w_id_nxt    = w_sel;
        end
      end
      S_REQ: begin
        // irq_id stays locked here; an accept outranks a withdrawn request.
        if (irq_ack) begin
          w_state_nxt = S_SVC;
          w_accept    = 1'b1;
        end else if (!r_en[r_irq_id] || !r_pend[r_irq_id]) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SVC: begin
        if (w_wr_stat) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_ack_nxt[i] = w_accept && (r_irq_id == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_en     <= 8'h00;
      r_pend   <= 8'h00;
      r_mode   <= 8'h00;
      r_eint_q <= 8'h00;
      r_irq_id <= 3'd0;
      r_ack    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_irq_id <= w_id_nxt;
      r_ack    <= w_ack_nxt;
      r_eint_q <= w_eint8;
      // Set is ORed in last so it beats both W1C and the ack-clear.
      r_pend   <= (r_pend & ~w_clr) | w_set;
      if (w_wr_en) begin
        r_en <= w_wdata;
      end
      if (w_wr_mode) begin
        r_mode <= w_wdata;
      end
    end
  end

  assign irq    = (r_state == S_REQ);
  assign in_svc = (r_state == S_SVC);
  assign irq_id = r_irq_id;
  assign ack    = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl_vec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_int_ctrl_vec                                               |
// | Purpose  : Self-checking bench for int_ctrl_vec: directed scenarios and  |
// |            randomized traffic against a behavioural reference model.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_int_ctrl_vec;

  localparam int         NCH  = 3;
  localparam logic [7:0] B    = 8'h10;
  localparam logic [7:0] MASK = 8'h07;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     add = 8'h00;
  logic [7:0]     data_i = 8'h00;
  logic [7:0]     data_o;
  logic           we = 1'b0;
  logic [NCH-1:0] eint = '0;
  logic           irq;
  logic [2:0]     irq_id;
  logic           irq_ack = 1'b0;
  logic [NCH-1:0] ack;
  logic           in_svc;

  int n_chk  = 0;
  int n_pass = 0;

  int_ctrl_vec #(.NCH(NCH), .BASE_ADD(B)) dut (
    .clk(clk), .rst(rst), .add(add), .data_i(data_i), .data_o(data_o),
    .we(we), .eint(eint), .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack),
    .ack(ack), .in_svc(in_svc)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Channel registers as plain bytes; the handshake is tracked as two
  // flags ("requesting", "in service") plus the id being offered.
  logic [7:0] m_en, m_pend, m_mode, m_last, m_ack;
  bit         m_irq, m_svc;
  int         m_id;

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_mode = 0; m_last = 0; m_ack = 0;
    m_irq = 0; m_svc = 0; m_id = 0;
  endtask

  task automatic model_step(input bit r, input bit w, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] e, input bit k);
    logic [7:0] off, set, clr, req, dm;
    if (r) begin
      model_reset();
      return;
    end
    off = a - B;
    dm  = d & MASK;
    set = 0;
    clr = 0;
    for (int i = 0; i < NCH; i++) begin
      if (m_mode[i]) set[i] = e[i] && !m_last[i];
      else           set[i] = e[i];
    end
    if (w && off == 2) set |= dm;
    if (w && off == 1) clr |= dm;
    req   = m_pend & m_en;
    m_ack = 0;
    if (m_irq) begin
      if (k) begin
        m_irq = 0; m_svc = 1;
        m_ack[m_id] = 1'b1;
        clr[m_id]   = 1'b1;
      end else if (!m_en[m_id] || !m_pend[m_id]) begin
        m_irq = 0;
      end
    end else if (m_svc) begin
      if (w && off == 4) m_svc = 0;
    end else if (req != 0) begin
      m_irq = 1;
      for (int i = 0; i < NCH; i++) begin
        if (req[i]) begin
          m_id = i;
          break;
        end
      end
    end
    m_pend = (m_pend & ~clr) | set;
    if (w && off == 0) m_en   = dm;
    if (w && off == 3) m_mode = dm;
    m_last = e & MASK;
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    logic [7:0] off;
    off = a - B;
    case (off)
      8'd0:    return m_en;
      8'd1:    return m_pend;
      8'd3:    return m_mode;
      8'd4:    return {m_irq, m_svc, 3'b000, 3'(m_id)};
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One bus cycle: drive on the falling edge, advance the model at the
  // rising edge, compare all outputs 1 time unit later.
  task automatic cyc(input bit r, input bit w, input logic [7:0] a,
                     input logic [7:0] d, input logic [7:0] e, input bit k);
    @(negedge clk);
    rst = r; we = w; add = a; data_i = d; eint = e[NCH-1:0]; irq_ack = k;
    @(posedge clk);
    model_step(r, w, a, d, e & MASK, k);
    #1;
    check("irq", irq, m_irq);
    check("in_svc", in_svc, m_svc);
    check("ack", ack, m_ack);
    if (m_irq) check("irq_id", irq_id, m_id);
    check("rd", data_o, model_rd(a));
  endtask

  task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] exp);
    we = 0; add = a;
    #1;
    check(tag, data_o, exp);
  endtask

  initial begin
    model_reset();

    // Reset with all sources high
    cyc(1, 0, B, 8'h00, 8'hFF, 0);
    cyc(1, 0, B, 8'h00, 8'hFF, 0);
    check("rst_irq", irq, 0);
    check("rst_ack", ack, 0);
    check("rst_svc", in_svc, 0);
    peek("rst_en", B + 0, 8'h00);
    peek("rst_pend", B + 1, 8'h00);
    peek("rst_mode", B + 3, 8'h00);

    // Edge mode, single source
    cyc(0, 1, B + 0, 8'h07, 8'h00, 0);
    cyc(0, 1, B + 3, 8'h07, 8'h00, 0);
    cyc(0, 0, B + 1, 8'h00, 8'h02, 0);
    check("edge_pend", data_o, 8'h02);
    check("edge_irq_lat", irq, 0);
    cyc(0, 0, B + 4, 8'h00, 8'h02, 0);
    check("edge_irq", irq, 1);
    check("edge_id", irq_id, 1);
    check("edge_stat", data_o, 8'h81);
    cyc(0, 0, B + 1, 8'h00, 8'h02, 1);
    check("edge_ack", ack, 3'b010);
    check("edge_svc", in_svc, 1);
    check("edge_pclr", data_o, 8'h00);
    cyc(0, 0, B + 4, 8'h00, 8'h02, 0);
    check("edge_ack1", ack, 3'b000);
    check("edge_stat_svc", data_o, 8'h41);
    cyc(0, 1, B + 4, 8'h00, 8'h02, 0);
    check("edge_eoi", in_svc, 0);

    // Priority and locked id
    cyc(0, 0, B + 1, 8'h00, 8'h00, 0);
    cyc(0, 0, B + 1, 8'h00, 8'h05, 0);
    check("prio_pend", data_o, 8'h05);
    cyc(0, 0, B + 4, 8'h00, 8'h05, 0);
    check("prio_id0", irq_id, 0);
    cyc(0, 0, B + 4, 8'h00, 8'h05, 1);
    cyc(0, 1, B + 4, 8'h00, 8'h05, 0);
    cyc(0, 0, B + 4, 8'h00, 8'h04, 0);
    check("prio_id2", irq_id, 2);
    cyc(0, 0, B + 1, 8'h00, 8'h05, 0);
    check("lock_id", irq_id, 2);
    check("lock_pend", data_o, 8'h05);
    cyc(0, 0, B + 1, 8'h00, 8'h05, 1);
    check("prio_ack2", ack, 3'b100);
    cyc(0, 1, B + 4, 8'h00, 8'h05, 0);
    cyc(0, 0, B + 4, 8'h00, 8'h05, 0);
    check("prio_id0b", irq_id, 0);
    cyc(0, 0, B + 4, 8'h00, 8'h05, 1);
    cyc(0, 1, B + 4, 8'h00, 8'h05, 0);

    // Mask, W1C, software set
    cyc(0, 1, B + 0, 8'h00, 8'h00, 0);
    cyc(0, 0, B + 1, 8'h00, 8'h01, 0);
    check("mask_pend", data_o, 8'h01);
    cyc(0, 0, B + 1, 8'h00, 8'h01, 0);
    check("mask_irq", irq, 0);
    cyc(0, 1, B + 1, 8'h01, 8'h01, 0);
    check("w1c", data_o, 8'h00);
    cyc(0, 1, B + 0, 8'h04, 8'h00, 0);
    cyc(0, 1, B + 2, 8'h04, 8'h00, 0);
    check("swi_rd", data_o, 8'h00);
    cyc(0, 0, B + 4, 8'h00, 8'h00, 0);
    check("swi_irq", irq, 1);
    check("swi_id", irq_id, 2);
    cyc(0, 0, B + 4, 8'h00, 8'h00, 1);
    cyc(0, 1, B + 4, 8'h00, 8'h00, 0);

    // Level mode and collisions
    cyc(0, 1, B + 3, 8'h00, 8'h00, 0);
    cyc(0, 1, B + 0, 8'h01, 8'h00, 0);
    cyc(0, 0, B + 1, 8'h00, 8'h01, 0);
    cyc(0, 0, B + 1, 8'h00, 8'h01, 0);
    check("lvl_irq", irq, 1);
    cyc(0, 0, B + 1, 8'h00, 8'h01, 1);
    check("lvl_ack", ack, 3'b001);
    check("lvl_repend", data_o, 8'h01);
    cyc(0, 1, B + 1, 8'h01, 8'h01, 0);
    check("w1c_vs_set", data_o, 8'h01);
    cyc(0, 1, B + 4, 8'h00, 8'h01, 0);

    // Reset in REQ (with a coinciding ack) and in SVC
    cyc(0, 0, B + 4, 8'h00, 8'h01, 0);
    check("pre_rst_req", irq, 1);
    cyc(1, 0, B + 4, 8'h00, 8'h01, 1);
    check("rst_req_irq", irq, 0);
    check("rst_req_ack", ack, 0);
    check("rst_req_svc", in_svc, 0);
    cyc(0, 1, B + 0, 8'h01, 8'h01, 0);
    cyc(0, 0, B + 4, 8'h00, 8'h01, 0);
    cyc(0, 0, B + 4, 8'h00, 8'h01, 1);
    check("pre_rst_svc", in_svc, 1);
    cyc(1, 0, B + 4, 8'h00, 8'h01, 0);
    check("rst_svc_svc", in_svc, 0);
    check("rst_svc_ack", ack, 0);

    // Randomized traffic
    begin
      logic [7:0] e_r, a_r;
      e_r = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 3) == 0) e_r = 8'($urandom());
        if ($urandom_range(0, 9) == 0) a_r = 8'($urandom());
        else                           a_r = B + 8'($urandom_range(0, 6)) - 8'd1;
        cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, a_r,
            8'($urandom()), e_r, $urandom_range(0, 2) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
